// File: rtl/idma_backend_arbiter_if.sv
// Handshake bundle between the frontends, the shared iDMA backend and the arbiter.
// The arbiter takes the slave modport; the surrounding system takes the master modport.
interface idma_backend_arbiter_if #(
  parameter int NumReq         = 4,
  parameter int ReqWidth       = 128,
  parameter int RspWidth       = 64,
  parameter int MaxOutstanding = 8
);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [NumReq*ReqWidth-1:0] req_i;
  logic [NumReq-1:0]          req_valid_i;
  logic [NumReq-1:0]          req_ready_o;
  logic [RspWidth-1:0]        rsp_o;
  logic [NumReq-1:0]          rsp_valid_o;
  logic [NumReq-1:0]          rsp_ready_i;
  logic [ReqWidth-1:0]        be_req_o;
  logic                       be_req_valid_o;
  logic                       be_req_ready_i;
  logic [RspWidth-1:0]        be_rsp_i;
  logic                       be_rsp_valid_i;
  logic                       be_rsp_ready_o;
  logic [CntW-1:0]            outstanding_o;
  logic                       busy_o;
  logic                       err_o;

  modport slave (
    input  req_i, req_valid_i, rsp_ready_i, be_req_ready_i, be_rsp_i, be_rsp_valid_i,
    output req_ready_o, rsp_o, rsp_valid_o, be_req_o, be_req_valid_o, be_rsp_ready_o,
           outstanding_o, busy_o, err_o
  );

  modport master (
    output req_i, req_valid_i, rsp_ready_i, be_req_ready_i, be_rsp_i, be_rsp_valid_i,
    input  req_ready_o, rsp_o, rsp_valid_o, be_req_o, be_req_valid_o, be_rsp_ready_o,
           outstanding_o, busy_o, err_o
  );
endinterface

// File: rtl/idma_backend_arbiter.sv
// Round-robin merge of NumReq frontends onto one iDMA backend; in-order responses are
// steered back to their requester through an owner FIFO.
//
// state     | meaning
// ST_FREE   | grant follows the round-robin search from rr_q
// ST_LOCKED | backend stalled a valid request; grant pinned to lock_idx_q
module idma_backend_arbiter #(
  parameter int NumReq         = 4,
  parameter int ReqWidth       = 128,
  parameter int RspWidth       = 64,
  parameter int MaxOutstanding = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  idma_backend_arbiter_if.slave bus
);
  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = $clog2(MaxOutstanding);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {ST_FREE, ST_LOCKED} lock_state_e;

  lock_state_e     state_q, state_d;
  logic [IdxW-1:0] rr_q, lock_idx_q;
  logic [IdxW-1:0] owner_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;

  logic [IdxW-1:0] pick, grant, head, cand;
  logic            found, full, empty, be_req_valid, req_hs, rsp_hs, spurious;
  int              idx;

  assign full  = (count_q == CntW'(MaxOutstanding));
  assign empty = (count_q == '0);
  assign head  = owner_q[rd_ptr_q];

  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      cand = IdxW'(idx);
      if (!found && bus.req_valid_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign grant = (state_q == ST_LOCKED) ? lock_idx_q : pick;

  // Outputs are held quiet while reset is asserted, not just after the next edge.
  always_comb begin
    be_req_valid       = !rst_i && !full && bus.req_valid_i[grant];
    req_hs             = be_req_valid && bus.be_req_ready_i;
    bus.be_req_valid_o = be_req_valid;
    bus.be_req_o       = bus.req_i[int'(grant)*ReqWidth +: ReqWidth];
    bus.req_ready_o    = '0;
    bus.req_ready_o[grant] = req_hs;
  end

  always_comb begin
    bus.rsp_o          = bus.be_rsp_i;
    bus.rsp_valid_o    = '0;
    bus.be_rsp_ready_o = 1'b1;
    rsp_hs             = 1'b0;
    spurious           = empty && bus.be_rsp_valid_i;
    if (!empty) begin
      bus.rsp_valid_o[head] = bus.be_rsp_valid_i;
      bus.be_rsp_ready_o    = bus.rsp_ready_i[head];
      rsp_hs                = bus.be_rsp_valid_i && bus.rsp_ready_i[head];
    end
  end

  assign bus.outstanding_o = count_q;
  assign bus.busy_o        = (count_q != '0) || be_req_valid;
  assign bus.err_o         = err_q;

  always_comb begin
    state_d = ST_FREE;
    if (be_req_valid && !bus.be_req_ready_i) state_d = ST_LOCKED;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_FREE;
      lock_idx_q <= '0;
      rr_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_LOCKED) lock_idx_q <= grant;
      if (req_hs) begin
        rr_q     <= (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
        wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rsp_hs) rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({req_hs, rsp_hs})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (spurious) err_q <= 1'b1;
    end
  end

  // Owner entries need no reset: the count alone decides which are live.
  always_ff @(posedge clk_i) begin
    if (req_hs) owner_q[wr_ptr_q] <= grant;
  end
endmodule

// File: tb/tb_idma_backend_arbiter.sv
// Directed and randomized checks of idma_backend_arbiter against a queue-based model
// of the arbitration and response-routing rules.
module tb_idma_backend_arbiter;
  localparam int NR = 4;
  localparam int RW = 128;
  localparam int SW = 64;
  localparam int MO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  idma_backend_arbiter_if #(.NumReq(NR), .ReqWidth(RW), .RspWidth(SW), .MaxOutstanding(MO)) bus();

  idma_backend_arbiter #(.NumReq(NR), .ReqWidth(RW), .RspWidth(SW), .MaxOutstanding(MO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int rr_m;
  bit lock_m;
  int lock_idx_m;
  int owners[$];
  bit err_m;
  // model update pending for the next edge
  bit p_push, p_pop, p_lock, p_spur;
  int p_g;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr_m = 0; lock_m = 0; lock_idx_m = 0; err_m = 0;
    owners.delete();
    p_push = 0; p_pop = 0; p_lock = 0; p_spur = 0; p_g = 0;
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NR; k++)
      bus.req_i[k*RW +: RW] = {$urandom, $urandom, $urandom, $urandom};
    bus.be_rsp_i = {$urandom, $urandom};
  endtask

  // Compare every output against the model for the current inputs, then record the
  // state change the next edge should make.
  task automatic check_now();
    int g, h, k;
    bit full, empty, bev;
    logic [NR-1:0] vld, rrdy, exp_rdy, exp_rv;
    logic [RW-1:0] slice;
    logic exp_bsr;
    #1;
    vld = bus.req_valid_i;
    rrdy = bus.rsp_ready_i;
    full = (owners.size() == MO);
    empty = (owners.size() == 0);
    g = -1;
    if (lock_m) g = lock_idx_m;
    else
      for (int i = 0; i < NR; i++) begin
        k = (rr_m + i) % NR;
        if (g < 0 && vld[k]) g = k;
      end
    bev = !full && (g >= 0) && vld[g];
    exp_rdy = '0;
    if (bev && bus.be_req_ready_i) exp_rdy[g] = 1'b1;
    chk("be_req_valid", bus.be_req_valid_o, bev);
    if (bev) begin
      slice = bus.req_i[g*RW +: RW];
      chk("be_req", bus.be_req_o, slice);
    end
    if (bev || full) chk("req_ready", bus.req_ready_o, exp_rdy);
    h = empty ? 0 : owners[0];
    exp_rv = '0;
    if (!empty && bus.be_rsp_valid_i) exp_rv[h] = 1'b1;
    exp_bsr = empty ? 1'b1 : rrdy[h];
    chk("rsp_valid", bus.rsp_valid_o, exp_rv);
    chk("be_rsp_ready", bus.be_rsp_ready_o, exp_bsr);
    if (bus.be_rsp_valid_i) chk("rsp_data", bus.rsp_o, bus.be_rsp_i);
    chk("outstanding", bus.outstanding_o, owners.size());
    chk("busy", bus.busy_o, (owners.size() != 0) || bev);
    chk("err", bus.err_o, err_m);
    p_push = bev && bus.be_req_ready_i;
    p_lock = bev && !bus.be_req_ready_i;
    p_g = g;
    p_pop = !empty && bus.be_rsp_valid_i && rrdy[h];
    p_spur = empty && bus.be_rsp_valid_i;
  endtask

  task automatic advance();
    @(posedge clk);
    if (p_pop) void'(owners.pop_front());
    if (p_push) begin
      owners.push_back(p_g);
      rr_m = (p_g + 1) % NR;
    end
    lock_m = p_lock;
    if (p_lock) lock_idx_m = p_g;
    if (p_spur) err_m = 1'b1;
    p_push = 0; p_pop = 0; p_lock = 0; p_spur = 0;
    #1;
  endtask

  task automatic drain();
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '1;
    for (int i = 0; i < 3 * MO && owners.size() > 0; i++) begin
      rand_payload();
      bus.be_rsp_valid_i = 1'b1;
      check_now();
      advance();
    end
    bus.be_rsp_valid_i = 1'b0;
    chk("drained", bus.outstanding_o, 0);
  endtask

  initial begin
    int acc;
    logic [NR-1:0] exp_v;
    int order [4] = '{3, 1, 1, 0};

    bus.req_i = '0; bus.req_valid_i = '0; bus.rsp_ready_i = '0;
    bus.be_req_ready_i = 1'b1; bus.be_rsp_i = '0; bus.be_rsp_valid_i = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_be_req_valid", bus.be_req_valid_o, 0);
    chk("rst_be_rsp_ready", bus.be_rsp_ready_o, 1);
    chk("rst_outstanding", bus.outstanding_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_err", bus.err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // round-robin with all requesters valid
    bus.req_valid_i = 4'hF; bus.be_req_ready_i = 1'b1; bus.rsp_ready_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      bus.be_rsp_valid_i = (owners.size() > 0);
      check_now();
      exp_v = '0; exp_v[i % 4] = 1'b1;
      chk("rr_grant", bus.req_ready_o, exp_v);
      advance();
    end
    drain();

    // lock stability
    rand_payload();
    bus.req_i[2*RW +: RW] = 128'hA5;
    bus.req_valid_i = 4'b0100; bus.be_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) bus.req_valid_i = 4'b0101;
      check_now();
      chk("lock_payload", bus.be_req_o, 128'hA5);
      advance();
    end
    bus.be_req_ready_i = 1'b1;
    check_now();
    chk("lock_grant2", bus.req_ready_o, 4'b0100);
    advance();
    bus.req_valid_i = 4'b0001;
    check_now();
    chk("lock_then0", bus.req_ready_o, 4'b0001);
    advance();
    drain();

    // full stall
    bus.req_valid_i = 4'hF; bus.be_req_ready_i = 1'b1; bus.be_rsp_valid_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      check_now();
      if (bus.be_req_valid_o && bus.be_req_ready_i) acc++;
      advance();
    end
    chk("full_accepts", acc, 8);
    chk("full_outstanding", bus.outstanding_o, 8);
    bus.be_rsp_valid_i = 1'b1; bus.rsp_ready_i = 4'hF;
    check_now();
    chk("full_pop_same_cycle", bus.be_req_valid_o, 0);
    advance();
    bus.be_rsp_valid_i = 1'b0;
    check_now();
    chk("full_reopen", bus.be_req_valid_o, 1);
    advance();
    chk("full_refill", bus.outstanding_o, 8);
    drain();

    // in-order routing
    bus.be_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid_i = '0;
      bus.req_valid_i[order[i]] = 1'b1;
      check_now();
      advance();
    end
    bus.req_valid_i = '0; bus.be_rsp_valid_i = 1'b1; bus.rsp_ready_i = 4'hF;
    check_now();
    chk("route_0", bus.rsp_valid_o, 4'b1000);
    advance();
    bus.rsp_ready_i = 4'b1101;
    for (int i = 0; i < 2; i++) begin
      check_now();
      chk("route_hold_ready", bus.be_rsp_ready_o, 0);
      chk("route_hold_valid", bus.rsp_valid_o, 4'b0010);
      advance();
    end
    bus.rsp_ready_i = 4'hF;
    check_now(); chk("route_1", bus.rsp_valid_o, 4'b0010); advance();
    check_now(); chk("route_2", bus.rsp_valid_o, 4'b0010); advance();
    check_now(); chk("route_3", bus.rsp_valid_o, 4'b0001); advance();
    bus.be_rsp_valid_i = 1'b0;

    // spurious response
    bus.be_rsp_valid_i = 1'b1;
    check_now();
    chk("spur_ready", bus.be_rsp_ready_o, 1);
    chk("spur_rsp_valid", bus.rsp_valid_o, 0);
    chk("spur_err_before", bus.err_o, 0);
    advance();
    bus.be_rsp_valid_i = 1'b0;
    check_now();
    chk("spur_err_after", bus.err_o, 1);
    advance();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      bus.req_valid_i = 4'($urandom_range(0, 15));
      bus.be_req_ready_i = ($urandom_range(0, 3) != 0);
      bus.be_rsp_valid_i = ($urandom_range(0, 2) != 0);
      bus.rsp_ready_i = 4'($urandom_range(0, 15));
      check_now();
      advance();
    end
    drain();

    // reset mid-operation with 5 outstanding and a held grant
    bus.be_req_ready_i = 1'b1; bus.req_valid_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      check_now();
      advance();
    end
    bus.req_valid_i = 4'b0110; bus.be_req_ready_i = 1'b0;
    check_now();
    advance();
    chk("pre_rst_outstanding", bus.outstanding_o, 5);
    #3;
    rst = 1'b1;
    bus.be_req_ready_i = 1'b1;
    #1;
    chk("midrst_outstanding", bus.outstanding_o, 0);
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_req_ready", bus.req_ready_o, 0);
    chk("midrst_err", bus.err_o, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid_i = 4'b1010;
    check_now();
    chk("rst_first_grant", bus.req_ready_o, 4'b0010);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
